mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multicycle load/store engine downstream of the control FSM, between AluOut/regB and the data memory.
- Control pulses a start with the effective address and funct3. The unit then:
  - sequences the memory access, honouring memory latency;
  - handles byte/half/word lanes;
  - sign- or zero-extends load data;
  - reports completion to the control FSM, which advances to the register-writeback or fetch state.

Parameters:
MEM_LATENCY, 1, cycles from mem_rd assertion to valid mem_rdata (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_read  in  1  load request, sampled only in IDLE
start_write  in  1  store request, sampled only in IDLE
funct3  in  3  access size/sign from INSTR[14:12]
addr  in  32  effective byte address (AluOut)
wdata  in  32  store data (regB)
mem_addr  out  32  word-aligned address to memory ({addr_q[31:2],2'b00})
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  out  32  lane-shifted store data
mem_rdata  in  32  memory read data
load_data  out  32  extended load result, held until the next completed load
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
fault  out  1  valid with done: misaligned access or illegal funct3; no memory access was made

Behaviour:
- Reset (async, immediate): state=IDLE. mem_rd, mem_wr, done, fault, busy=0. mem_be=0. mem_addr, mem_wdata, load_data=0. Counter=0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On a start, latch addr, funct3 and wdata into addr_q/f3_q/wd_q.
  - If start_read and start_write are both high, the read wins; the write is dropped.
- Fault check at start:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - On fault: go to DONE with fault_q=1, no memory access.
  - Otherwise: a load goes to RD with counter=MEM_LATENCY-1; a store goes to WR.
- RD:
  - mem_rd=1; mem_be = lanes of the access (byte 0001<<a, half 0011<<a, word 1111).
  - If counter≠0, decrement the counter.
  - If counter=0, capture the extended lane data into load_data and go to DONE.
- Load extraction: the byte is mem_rdata[8a+7:8a] and the half is mem_rdata[8a+15:8a], where a=addr_q[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- WR:
  - mem_wr=1 for exactly one cycle.
  - mem_be as in RD.
  - mem_wdata = wd_q shifted left by 8*a for byte/half; unused lanes are don't-care but driven as the replicated value.
  - Then go to DONE.
- DONE: done=1 and fault=fault_q for one cycle, then IDLE.
- Start inputs are ignored while busy. A start in the DONE cycle is not accepted; it is sampled in the next IDLE cycle.
- Latency:
  - Load: done is high in cycle MEM_LATENCY+1 after the start cycle (cycle 2 for the default).
  - Store: done is high in cycle 2.
  - Fault: done is high in cycle 1.
- mem_rd/mem_wr are never high together and never high outside RD/WR.
- load_data changes only on a successful load capture or on reset. Stores and faults leave it unchanged.
- Reset mid-operation aborts immediately: strobes drop in the same cycle, no done pulse, state=IDLE.

Test Plan:
- Reset → all outputs 0, busy=0; assert rst during RD → mem_rd drops at once, no done pulse.
- LW addr=0x0000_0104, mem_rdata=0xDEAD_BEEF, MEM_LATENCY=1 → mem_addr=0x104, mem_be=1111, done in cycle 2, load_data=0xDEAD_BEEF, fault=0.
- LB addr=0x103, mem_rdata=0x80FF_0000 → load_data=0xFFFF_FF80; LBU on the same access → 0x0000_0080; LH addr=0x102 → 0xFFFF_80FF.
- SB addr=0x201, wdata=0x0000_00AB → one cycle mem_wr=1, mem_be=0010, mem_wdata[15:8]=0xAB, mem_addr=0x200; SH addr=0x202 → mem_be=1100.
- LW addr=0x102 or funct3=011 → done with fault=1 in cycle 1, mem_rd/mem_wr never asserted, load_data unchanged.
- MEM_LATENCY=3: mem_rd held 3 cycles, done in cycle 4; start_read and start_write together → read performed, no mem_wr; start pulsed while busy → ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer between the datapath and data memory.
// Handles lane selection, load extension, memory latency and fault reporting.
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_read,
  input  logic        i_start_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_load_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wd, r_load_data;
  logic [2:0]  r_f3;
  logic        r_fault;
  logic [3:0]  r_cnt;

  logic        w_start, w_legal, w_misal, w_fault;
  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_shift, w_ext, w_wdata;

  assign w_start = i_start_read | i_start_write;

  // Legality depends on direction; a simultaneous read/write request is a read.
  always_comb begin
    w_legal = 1'b0;
    if (i_start_read) begin
      case (i_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end
    w_misal = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
              ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    w_fault = !w_legal || w_misal;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_fault)           w_next = S_DONE;
          else if (i_start_read) w_next = S_RD;
          else                   w_next = S_WR;
        end
      end
      S_RD:    if (r_cnt == 4'd0) w_next = S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_wd        <= '0;
      r_f3        <= '0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= '0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_addr  <= i_addr;
      r_f3    <= i_funct3;
      r_wd    <= i_wdata;
      r_fault <= w_fault;
      r_cnt   <= 4'(MEM_LATENCY - 1);
    end else if (r_state == S_RD) begin
      if (r_cnt != 4'd0) r_cnt       <= r_cnt - 4'd1;
      else               r_load_data <= w_ext;
    end
  end

  assign w_a     = r_addr[1:0];
  assign w_shift = i_mem_rdata >> {w_a, 3'b000};

  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_be = 4'b0001 << w_a;
      2'b01:   w_be = 4'b0011 << w_a;
      default: w_be = 4'b1111;
    endcase
    case (r_f3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ext = {24'd0, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ext = {16'd0, w_shift[15:0]};
      default: w_ext = i_mem_rdata;
    endcase
    // Replication places the data in the addressed lane(s) for any aligned offset.
    case (r_f3[1:0])
      2'b00:   w_wdata = {4{r_wd[7:0]}};
      2'b01:   w_wdata = {2{r_wd[15:0]}};
      default: w_wdata = r_wd;
    endcase
  end

  assign o_mem_rd    = (r_state == S_RD);
  assign o_mem_wr    = (r_state == S_WR);
  assign o_mem_be    = (o_mem_rd || o_mem_wr) ? w_be : 4'b0000;
  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_mem_wdata = w_wdata;
  assign o_load_data = r_load_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_fault     = o_done && r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: two units (latency 1 and 3) run the same access sequence,
// each checked against queued expectations when it strobes memory or completes.
module tb_mem_access_unit;

  typedef struct {
    bit          fault;
    logic [31:0] ld;
    int          lat;
    int          nrd;
    int          nwr;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wd;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, srd = 1'b0, swr = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wdata = '0, mword = '0, last_ld = '0;
  int          cyc = 0, t0 = 0, n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : u
    localparam int LAT = (d == 0) ? 1 : 3;
    logic [31:0] maddr, mwd, rdata, ld;
    logic        mrd, mwr, busy, done, flt;
    logic [3:0]  be;
    int          run = 0, rdc = 0, wrc = 0;
    exp_t        q[$];
    exp_t        e;

    mem_access_unit #(.MEM_LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_start_read(srd), .i_start_write(swr),
      .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
      .o_mem_addr(maddr), .o_mem_rd(mrd), .o_mem_wr(mwr), .o_mem_be(be),
      .o_mem_wdata(mwd), .i_mem_rdata(rdata), .o_load_data(ld),
      .o_busy(busy), .o_done(done), .o_fault(flt)
    );

    // Memory returns the real word only in the LAT-th read cycle.
    always @(posedge clk) run <= mrd ? run + 1 : 0;
    assign rdata = (mrd && run == LAT - 1) ? mword : 32'h5A5A_A5A5;

    always @(negedge clk) begin
      if (rst) begin
        rdc = 0;
        wrc = 0;
      end else begin
        if (mrd && mwr) chk("rd_wr_overlap", 32'd1, 32'd0);
        if ((mrd || mwr || done) && q.size() == 0) begin
          chk("unexpected_activity", {29'd0, mrd, mwr, done}, 32'd0);
        end else begin
          if (mrd) begin
            rdc++;
            chk("rd_be", 32'(be), 32'(q[0].be));
            chk("rd_addr", maddr, q[0].maddr);
          end
          if (mwr) begin
            wrc++;
            chk("wr_be", 32'(be), 32'(q[0].be));
            chk("wr_addr", maddr, q[0].maddr);
            chk("wr_data", mwd & bmask(q[0].be), q[0].wd & bmask(q[0].be));
          end
          if (done) begin
            e = q.pop_front();
            chk("fault", 32'(flt), 32'(e.fault));
            chk("load_data", ld, e.ld);
            chk("done_cycle", 32'(cyc - t0 + 1), 32'(e.lat));
            chk("rd_cycles", 32'(rdc), 32'(e.nrd));
            chk("wr_cycles", 32'(wrc), 32'(e.nwr));
            rdc = 0;
            wrc = 0;
          end
        end
      end
    end
  end

  task automatic op(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] mw, input bit flt,
                    input logic [3:0] xbe, input logic [31:0] xld, input logic [31:0] xwd,
                    input bit poke);
    exp_t e;
    if (rd && !flt) last_ld = xld;
    e.fault = flt;  e.ld = last_ld;  e.be = xbe;
    e.maddr = {a[31:2], 2'b00};  e.wd = xwd;
    e.nwr   = (!flt && !rd) ? 1 : 0;
    e.lat   = flt ? 1 : 2;
    e.nrd   = (!flt && rd) ? 1 : 0;
    u[0].q.push_back(e);
    e.lat   = flt ? 1 : (rd ? 4 : 2);
    e.nrd   = (!flt && rd) ? 3 : 0;
    u[1].q.push_back(e);
    @(posedge clk); #1;
    srd = rd; swr = wr; f3 = f; addr = a; wdata = wd; mword = mw;
    @(posedge clk); #1;
    t0 = cyc; srd = 1'b0; swr = 1'b0;
    addr = $urandom; wdata = $urandom;
    chk("busy0", 32'(u[0].busy), 32'(flt ? 1'b1 : 1'b1));
    chk("busy1", 32'(u[1].busy), 32'd1);
    if (poke) begin
      srd = 1'b1; swr = 1'b1; f3 = 3'b010; addr = 32'h0000_0800;
      @(posedge clk); #1;
      @(posedge clk); #1;
      srd = 1'b0; swr = 1'b0;
    end
    for (int k = 0; k < 40 && (u[0].q.size() != 0 || u[1].q.size() != 0); k++) @(negedge clk);
    if (u[0].q.size() != 0 || u[1].q.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      u[0].q.delete();
      u[1].q.delete();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd0"},   32'(u[0].mrd),  32'd0);
    chk({tag, "_wr0"},   32'(u[0].mwr),  32'd0);
    chk({tag, "_be0"},   32'(u[0].be),   32'd0);
    chk({tag, "_busy0"}, 32'(u[0].busy), 32'd0);
    chk({tag, "_done0"}, 32'(u[0].done), 32'd0);
    chk({tag, "_flt0"},  32'(u[0].flt),  32'd0);
    chk({tag, "_ld0"},   u[0].ld,        32'd0);
    chk({tag, "_addr0"}, u[0].maddr,     32'd0);
    chk({tag, "_wd0"},   u[0].mwd,       32'd0);
    chk({tag, "_rd1"},   32'(u[1].mrd),  32'd0);
    chk({tag, "_busy1"}, 32'(u[1].busy), 32'd0);
    chk({tag, "_done1"}, 32'(u[1].done), 32'd0);
    chk({tag, "_ld1"},   u[1].ld,        32'd0);
  endtask

  initial begin
    logic [31:0] w;
    repeat (2) @(posedge clk);
    #1 chk_idle("reset");
    rst = 1'b0;

    //  rd wr  f3      addr          wdata         mem word      flt be       exp ld        exp wdata     poke
    op(1, 0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0);
    op(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 4'b1000, 32'hFFFF_FF80, 32'h0,        0);
    op(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 4'b1000, 32'h0000_0080, 32'h0,        0);
    op(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 0, 4'b1100, 32'hFFFF_80FF, 32'h0,        0);
    op(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_0000, 0, 4'b1100, 32'h0000_80FF, 32'h0,        0);
    op(1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 4'b0010, 32'h0000_007F, 32'h0,        0);
    op(0, 1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,        0, 4'b0010, 32'h0,         32'h0000_AB00, 0);
    op(0, 1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,        0, 4'b1100, 32'h0,         32'h1234_0000, 0);
    op(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        0, 4'b1111, 32'h0,         32'hCAFE_F00D, 0);
    op(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h1111_1111, 1, 4'b0000, 32'h0,         32'h0,        0);
    op(1, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h1111_1111, 1, 4'b0000, 32'h0,         32'h0,        0);
    op(0, 1, 3'b001, 32'h0000_0201, 32'h0000_5555, 32'h0,        1, 4'b0000, 32'h0,         32'h0,        0);
    op(0, 1, 3'b100, 32'h0000_0200, 32'h0000_5555, 32'h0,        1, 4'b0000, 32'h0,         32'h0,        0);
    op(1, 1, 3'b010, 32'h0000_0040, 32'h9999_9999, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, 32'h0,       0);
    op(1, 0, 3'b010, 32'h0000_0480, 32'h0,        32'h0BAD_F00D, 0, 4'b1111, 32'h0BAD_F00D, 32'h0,        1);
    op(0, 1, 3'b000, 32'h0000_0503, 32'h0000_00C3, 32'h0,        0, 4'b1000, 32'h0,         32'hC300_0000, 1);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      op(1, 0, 3'b010, {$urandom_range(0, 4095), 2'b00}, 32'h0, w, 0, 4'b1111, w, 32'h0, 0);
    end

    // Reset in the middle of a read must drop the strobe immediately.
    @(posedge clk); #1;
    srd = 1'b1; f3 = 3'b010; addr = 32'h0000_0100; mword = 32'h7777_7777;
    @(posedge clk); #1;
    srd = 1'b0;
    chk("pre_rst_rd1", 32'(u[1].mrd), 32'd1);
    #2 rst = 1'b1;
    #1 chk_idle("abort");
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_done0", 32'(u[0].done), 32'd0);
      chk("rst_done1", 32'(u[1].done), 32'd0);
    end
    rst = 1'b0;
    last_ld = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_busy1", 32'(u[1].busy), 32'd0);
    end
    op(1, 0, 3'b001, 32'h0000_0100, 32'h0, 32'h0000_8001, 0, 4'b0011, 32'hFFFF_8001, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
